// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit: program-counter owner for the multicycle core.
// Fetches through a ready handshake, hands each instruction to the
// executor, resolves branches from N/V/Z, and stops on halt or on a
// memory watchdog timeout.
// Optional feature macro: LINK_EN (BL/BLX write the return address to R7).
// Assumes WAIT_W >= 2.
module fetch_branch_unit #(
  parameter int ADDR_W   = 9,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0,
  parameter int WAIT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [1:0]         mem_cmd,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] read_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               exec_done,
  input  logic               br_req,
  input  logic [2:0]         br_cond,
  input  logic [1:0]         br_kind,
  input  logic [7:0]         br_off,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               N,
  input  logic               V,
  input  logic               Z,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               link_we,
  output logic [ADDR_W-1:0]  link_data,
  output logic               halted,
  output logic               fault
);

  localparam logic [1:0]        CMD_IDLE  = 2'b00;
  localparam logic [1:0]        CMD_READ  = 2'b01;
  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);
  // The fault fires on the not-ready cycle that would make the counter all-ones.
  localparam logic [WAIT_W-1:0] WAIT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_HALT,
    S_FAULT
  } state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    pc_q;
  logic [INSTR_W-1:0]   ir_q;
  logic [WAIT_W-1:0]    wait_q;
  logic [1:0]           mem_cmd_q;
  logic                 ir_valid_q;
  logic                 halted_q;
  logic                 fault_q;
  logic                 link_we_q;
  logic [ADDR_W-1:0]    link_data_q;

  logic                 cond_taken;
  logic                 br_taken;
  logic                 do_link;
  logic [ADDR_W-1:0]    off_sext;
  logic [ADDR_W-1:0]    br_pc_d;

`ifdef LINK_EN
  assign do_link = br_kind[1];
`else
  // Without the link feature BL/BLX degrade to their plain branch forms.
  logic kind_link_unused;
  assign kind_link_unused = br_kind[1];
  assign do_link          = 1'b0;
`endif

  // Condition decode from the ALU flags; reserved codes are never taken.
  always_comb begin
    cond_taken = 1'b0;
    case (br_cond)
      3'b000:  cond_taken = 1'b1;
      3'b001:  cond_taken = Z;
      3'b010:  cond_taken = ~Z;
      3'b011:  cond_taken = N ^ V;
      3'b100:  cond_taken = (N ^ V) | Z;
      default: cond_taken = 1'b0;
    endcase
  end

  // Register-target kinds ignore the condition and always branch.
  assign br_taken = br_kind[0] | cond_taken;
  assign off_sext = ADDR_W'($signed(br_off));
  assign br_pc_d  = br_kind[0] ? br_target : (pc_q + off_sext);

  // Control FSM with registered outputs; mem_cmd is set on the edge entering FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RST;
      pc_q        <= PC_INIT;
      ir_q        <= '0;
      wait_q      <= '0;
      mem_cmd_q   <= CMD_IDLE;
      ir_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
    end else begin
      ir_valid_q <= 1'b0;
      link_we_q  <= 1'b0;
      case (state_q)
        S_RST: begin
          state_q   <= S_FETCH;
          mem_cmd_q <= CMD_READ;
        end
        S_FETCH: begin
          if (mem_ready) begin
            ir_q       <= read_data;
            pc_q       <= pc_q + ADDR_W'(1);
            wait_q     <= '0;
            ir_valid_q <= 1'b1;
            mem_cmd_q  <= CMD_IDLE;
            state_q    <= S_ISSUE;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
            if (wait_q == WAIT_LAST) begin
              fault_q   <= 1'b1;
              mem_cmd_q <= CMD_IDLE;
              state_q   <= S_FAULT;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_done) begin
            if (halt) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              if (br_req && br_taken) begin
                pc_q <= br_pc_d;
                if (do_link) begin
                  link_we_q   <= 1'b1;
                  link_data_q <= pc_q;
                end
              end
              mem_cmd_q <= CMD_READ;
              state_q   <= S_FETCH;
            end
          end
        end
        S_HALT, S_FAULT: begin
          mem_cmd_q <= CMD_IDLE;
        end
        default: begin
          mem_cmd_q <= CMD_IDLE;
          state_q   <= S_RST;
        end
      endcase
    end
  end

  assign mem_addr  = pc_q;
  assign mem_cmd   = mem_cmd_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign link_we   = link_we_q;
  assign link_data = link_data_q;

endmodule

// File: tb/tb_fetch_branch_unit.sv
// Bench for fetch_branch_unit: a cycle model built from the fetch/issue/execute
// rules is compared against the DUT on every falling edge, and directed
// scenarios add hand-computed literal expectations.
module tb_fetch_branch_unit;
  localparam int ADDR_W   = 9;
  localparam int INSTR_W  = 16;
  localparam int RESET_PC = 0;
  localparam int WAIT_W   = 4;
  localparam int AMOD     = 1 << ADDR_W;
`ifdef LINK_EN
  localparam bit LINK = 1'b1;
`else
  localparam bit LINK = 1'b0;
`endif
  localparam int P_RST = 0, P_FETCH = 1, P_ISSUE = 2, P_EXEC = 3, P_HALT = 4, P_FAULT = 5;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               mem_ready = 1'b0;
  logic [INSTR_W-1:0] read_data = '0;
  logic               exec_done = 1'b0;
  logic               br_req = 1'b0;
  logic [2:0]         br_cond = '0;
  logic [1:0]         br_kind = '0;
  logic [7:0]         br_off = '0;
  logic [ADDR_W-1:0]  br_target = '0;
  logic               N = 1'b0, V = 1'b0, Z = 1'b0;
  logic               halt = 1'b0;
  logic [ADDR_W-1:0]  mem_addr, pc, link_data;
  logic [1:0]         mem_cmd;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid, link_we, halted, fault;

  fetch_branch_unit #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(RESET_PC), .WAIT_W(WAIT_W)
  ) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_cmd(mem_cmd),
    .mem_ready(mem_ready), .read_data(read_data), .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .br_req(br_req), .br_cond(br_cond), .br_kind(br_kind),
    .br_off(br_off), .br_target(br_target), .N(N), .V(V), .Z(Z), .halt(halt),
    .pc(pc), .link_we(link_we), .link_data(link_data), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int m_ph = P_RST, m_pc = RESET_PC, m_ir = 0, m_wait = 0, m_lwe = 0, m_ldata = 0;
  bit m_halted = 1'b0, m_fault = 1'b0;

  function automatic bit taken_rule(input logic [2:0] c, input logic [1:0] k,
                                    input logic n, input logic v, input logic z);
    if (k == 2'b01 || k == 2'b11) return 1'b1;
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n != v;
      3'd4:    return (n != v) || z;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    m_lwe = 0;
    if (reset) begin
      m_ph = P_RST; m_pc = RESET_PC; m_ir = 0; m_wait = 0;
      m_halted = 1'b0; m_fault = 1'b0; m_ldata = 0;
    end else begin
      case (m_ph)
        P_RST:   m_ph = P_FETCH;
        P_FETCH: begin
          if (mem_ready) begin
            m_ir = int'(read_data); m_pc = (m_pc + 1) % AMOD; m_wait = 0; m_ph = P_ISSUE;
          end else begin
            m_wait++;
            if (m_wait == (1 << WAIT_W) - 1) begin m_fault = 1'b1; m_ph = P_FAULT; end
          end
        end
        P_ISSUE: m_ph = P_EXEC;
        P_EXEC: begin
          if (exec_done) begin
            if (halt) begin
              m_halted = 1'b1; m_ph = P_HALT;
            end else begin
              if (br_req && taken_rule(br_cond, br_kind, N, V, Z)) begin
                if (LINK && br_kind[1]) begin m_lwe = 1; m_ldata = m_pc; end
                if (br_kind[0]) m_pc = int'(br_target);
                else m_pc = (m_pc + int'($signed(br_off)) + AMOD) % AMOD;
              end
              m_ph = P_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("mem_cmd",   32'(mem_cmd),   (m_ph == P_FETCH) ? 32'd1 : 32'd0);
      check("mem_addr",  32'(mem_addr),  m_pc);
      check("pc",        32'(pc),        m_pc);
      check("ir",        32'(ir),        m_ir);
      check("ir_valid",  32'(ir_valid),  (m_ph == P_ISSUE) ? 32'd1 : 32'd0);
      check("link_we",   32'(link_we),   m_lwe);
      check("link_data", 32'(link_data), m_ldata);
      check("halted",    32'(halted),    32'(m_halted));
      check("fault",     32'(fault),     32'(m_fault));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_phase(input int ph);
    int n = 0;
    while (m_ph != ph && n < 40) begin @(negedge clk); n++; end
    check("wait_phase", m_ph, ph);
  endtask

  // One fetch; during the stall cycles exec_done/halt are waved to show they are ignored.
  task automatic fetch(input logic [15:0] d, input int dly);
    wait_phase(P_FETCH);
    $display("fetch  addr=0x%0h data=0x%0h stall=%0d", m_pc, d, dly);
    for (int i = 0; i < dly; i++) begin
      exec_done = 1'b1; halt = 1'b1;
      @(negedge clk);
    end
    exec_done = 1'b0; halt = 1'b0;
    mem_ready = 1'b1; read_data = d;
    @(negedge clk);
    mem_ready = 1'b0; read_data = 16'($urandom);
  endtask

  task automatic exec(input int dly, input logic brq, input logic [2:0] cond,
                      input logic [1:0] kind, input logic [7:0] off,
                      input logic [8:0] tgt, input logic [2:0] nvz, input logic hlt,
                      output int pc_before);
    wait_phase(P_EXEC);
    pc_before = m_pc;
    repeat (dly) @(negedge clk);
    $display("exec   pc=0x%0h br=%0b cond=%0d kind=%0d off=0x%0h tgt=0x%0h nvz=%03b halt=%0b",
             m_pc, brq, cond, kind, off, tgt, nvz, hlt);
    br_req = brq; br_cond = cond; br_kind = kind; br_off = off; br_target = tgt;
    {N, V, Z} = nvz; halt = hlt; exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0; br_req = 1'b0; halt = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  int pb;
  logic [7:0] lt_mask, le_mask;

  initial begin
    lt_mask = 8'b0011_1100;   // indexed by {N,V,Z}: taken when N!=V
    le_mask = 8'b1011_1110;   // N!=V or Z

    // Reset values
    @(negedge clk);
    cmp_en = 1'b1;
    check("lit_rst_pc", 32'(pc), 32'd0);
    check("lit_rst_cmd", 32'(mem_cmd), 32'd0);
    check("lit_rst_ir", 32'(ir), 32'd0);
    check("lit_rst_flags", {28'd0, ir_valid, link_we, halted, fault}, 32'd0);
    reset = 1'b0;

    // First fetch, zero-wait memory
    @(negedge clk);
    check("lit_first_cmd", 32'(mem_cmd), 32'd1);
    check("lit_first_addr", 32'(mem_addr), 32'd0);
    mem_ready = 1'b1; read_data = 16'hA5A5;
    @(negedge clk);
    mem_ready = 1'b0;
    check("lit_first_ir", 32'(ir), 32'hA5A5);
    check("lit_first_irv", 32'(ir_valid), 32'd1);
    check("lit_first_pc", 32'(pc), 32'd1);
    exec(2, 1'b0, 3'd0, 2'b00, 8'h00, 9'h000, 3'b000, 1'b0, pb);
    check("lit_nobr_addr", 32'(mem_addr), 32'd1);
    check("lit_nobr_cmd", 32'(mem_cmd), 32'd1);

    // BX to 5 (reserved cond ignored for register kinds), then EQ taken from instruction at 5
    fetch(16'h1111, 2);
    exec(0, 1'b1, 3'd7, 2'b01, 8'h00, 9'd5, 3'b000, 1'b0, pb);
    check("lit_bx_addr", 32'(mem_addr), 32'd5);
    fetch(16'h2222, 0);
    exec(1, 1'b1, 3'd1, 2'b00, 8'hFD, 9'h000, 3'b001, 1'b0, pb);
    check("lit_eq_taken_pc", 32'(pc), 32'd3);     // pc reg 6 plus -3
    check("lit_eq_taken_addr", 32'(mem_addr), 32'd3);
    fetch(16'h3333, 0);
    exec(0, 1'b1, 3'd1, 2'b01, 8'h00, 9'd5, 3'b000, 1'b0, pb);
    fetch(16'h4444, 0);
    exec(0, 1'b1, 3'd1, 2'b00, 8'hFD, 9'h000, 3'b000, 1'b0, pb);
    check("lit_eq_nt_pc", 32'(pc), 32'd6);

    // LT and LE over every flag combination, offset +2
    for (int c = 3; c <= 4; c++) begin
      for (int f = 0; f < 8; f++) begin
        fetch(16'(f), 0);
        exec(0, 1'b1, 3'(c), 2'b00, 8'd2, 9'h000, 3'(f), 1'b0, pb);
        check((c == 3) ? "lit_lt_pc" : "lit_le_pc", 32'(pc),
              32'((pb + (((c == 3) ? lt_mask[f] : le_mask[f]) ? 2 : 0)) % AMOD));
      end
    end
    // Reserved conditions never branch, regardless of flags
    for (int c = 5; c <= 7; c++) begin
      fetch(16'hC000 | 16'(c), 0);
      exec(0, 1'b1, 3'(c), 2'b00, 8'd4, 9'h000, 3'b111, 1'b0, pb);
      check("lit_never_pc", 32'(pc), 32'(pb));
    end

    // BLX from pc=20 to 0x1F0
    fetch(16'h5555, 0);
    exec(0, 1'b1, 3'd0, 2'b01, 8'h00, 9'd19, 3'b000, 1'b0, pb);
    fetch(16'h6666, 1);
    exec(0, 1'b1, 3'd0, 2'b11, 8'h00, 9'h1F0, 3'b000, 1'b0, pb);
    check("lit_blx_addr", 32'(mem_addr), 32'h1F0);
    check("lit_blx_we", 32'(link_we), LINK ? 32'd1 : 32'd0);
    check("lit_blx_data", 32'(link_data), LINK ? 32'd20 : 32'd0);
    @(negedge clk);
    check("lit_blx_we_pulse", 32'(link_we), 32'd0);

    // BL at 0x1F0: 0x1F1 + 0x20 wraps to 0x011
    fetch(16'h7777, 0);
    exec(0, 1'b1, 3'd0, 2'b10, 8'h20, 9'h000, 3'b000, 1'b0, pb);
    check("lit_bl_wrap_pc", 32'(pc), 32'h011);
    check("lit_bl_data", 32'(link_data), LINK ? 32'h1F1 : 32'd0);

    // Watchdog: 15 consecutive not-ready cycles
    wait_phase(P_FETCH);
    repeat (14) @(negedge clk);
    check("lit_wd_14_fault", 32'(fault), 32'd0);
    check("lit_wd_14_cmd", 32'(mem_cmd), 32'd1);
    @(negedge clk);
    check("lit_wd_15_fault", 32'(fault), 32'd1);
    check("lit_wd_15_cmd", 32'(mem_cmd), 32'd0);
    mem_ready = 1'b1; exec_done = 1'b1;
    repeat (3) @(negedge clk);
    check("lit_fault_sticky", 32'(fault), 32'd1);
    mem_ready = 1'b0; exec_done = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("lit_wd_rst_fault", 32'(fault), 32'd0);
    check("lit_wd_rst_pc", 32'(pc), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("lit_wd_resume", {23'd0, mem_cmd, mem_addr}, {23'd0, 2'b01, 9'd0});

    // Halt wins over a simultaneous branch
    fetch(16'h8888, 0);
    exec(0, 1'b1, 3'd0, 2'b00, 8'd5, 9'h000, 3'b000, 1'b1, pb);
    check("lit_halt_halted", 32'(halted), 32'd1);
    check("lit_halt_pc", 32'(pc), 32'd1);
    mem_ready = 1'b1; exec_done = 1'b1; br_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lit_halt_cmd", 32'(mem_cmd), 32'd0);
    end
    mem_ready = 1'b0; exec_done = 1'b0; br_req = 1'b0;

    // Reset mid-fetch
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_phase(P_FETCH);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("lit_midfetch_cmd", 32'(mem_cmd), 32'd0);
    check("lit_midfetch_halted", 32'(halted), 32'd0);
    reset = 1'b0;
    fetch(16'h9999, 1);
    exec(0, 1'b0, 3'd0, 2'b00, 8'h00, 9'h000, 3'b000, 1'b0, pb);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
